// File: rtl/nlf_pkg.sv
// Shared types and constants for the NLF step sequencer tile: FSM states,
// datapath widths and the bit map of the io_in/io_out pins.
package nlf_pkg;

  localparam int NLF_W = 8;
  localparam int CNT_W = 5;
  localparam int IO_W  = 8;

  localparam int IN_CLK     = 0;
  localparam int IN_RST_N   = 1;
  localparam int IN_START   = 2;
  localparam int IN_LOAD    = 3;
  localparam int IN_SDI     = 4;
  localparam int IN_SEL_LSB = 5;
  localparam int IN_SEL_MSB = 7;

  localparam int OUT_BUSY  = 0;
  localparam int OUT_DONE  = 1;
  localparam int OUT_KS1   = 2;
  localparam int OUT_KS0   = 3;
  localparam int OUT_S_LSB = 4;
  localparam int OUT_S_MSB = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nlf_core.sv
// Two-output nonlinear feedback function of the 8-bit state; purely
// combinational so it can be checked on its own.
module nlf_core
  import nlf_pkg::*;
(
  input  logic [NLF_W-1:0] s,
  output logic             f1,
  output logic             f0
);

  assign f1 = s[0] ^ (s[1] ? s[2] : s[3]) ^ (s[3] & s[4]);
  assign f0 = s[5] ^ (s[2] & ~s[4]) ^ (s[2] & s[6]) ^ (s[4] & s[7]);

endmodule

// File: rtl/nlf_step_sequencer.sv
// Tile top: serial state load, programmable-length run of the feedback step,
// busy/done handshake and registered keystream/state nibble on io_out.
module nlf_step_sequencer
  import nlf_pkg::*;
#(
  parameter int ROUNDS_BASE = 2
) (
  input  logic [IO_W-1:0] io_in,
  output logic [IO_W-1:0] io_out
);

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       load;
  logic       sdi;
  logic [2:0] sel;

  assign clk   = io_in[IN_CLK];
  assign rst_n = io_in[IN_RST_N];
  assign start = io_in[IN_START];
  assign load  = io_in[IN_LOAD];
  assign sdi   = io_in[IN_SDI];
  assign sel   = io_in[IN_SEL_MSB:IN_SEL_LSB];

  state_e           state_q, state_d;
  logic [NLF_W-1:0] s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ks1_q, ks1_d;
  logic             ks0_q, ks0_d;
  logic             busy_q;
  logic             done_q;
  logic             f1, f0;
  logic [CNT_W-1:0] rounds;

  nlf_core u_core (
    .s  (s_q),
    .f1 (f1),
    .f0 (f0)
  );

  assign rounds = CNT_W'(ROUNDS_BASE * (int'(sel) + 1));

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    ks1_d   = ks1_q;
    ks0_d   = ks0_q;
    case (state_q)
      ST_IDLE: begin
        // load has priority over start when both are high
        if (load) begin
          s_d = {sdi, s_q[NLF_W-1:1]};
        end else if (start) begin
          cnt_d   = rounds;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        s_d   = {f1, f0, s_q[NLF_W-1:2]};
        ks1_d = f1;
        ks0_d = f0;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      cnt_q   <= '0;
      ks1_q   <= 1'b0;
      ks0_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      ks1_q   <= ks1_d;
      ks0_q   <= ks0_d;
      // flags decoded from the next state so they are flops aligned with it
      busy_q  <= (state_d == ST_RUN);
      done_q  <= (state_d == ST_DONE);
    end
  end

  always_comb begin
    io_out                        = '0;
    io_out[OUT_BUSY]              = busy_q;
    io_out[OUT_DONE]              = done_q;
    io_out[OUT_KS1]               = ks1_q;
    io_out[OUT_KS0]               = ks0_q;
    io_out[OUT_S_MSB:OUT_S_LSB]   = s_q[NLF_W-1:NLF_W-4];
  end

endmodule
